// File: rtl/mem_to_banks_sized.sv
// mem_to_banks_sized: splits one sized memory request into per-bank requests.
//   The byte range selected by addr_i/size_i (plus the write strobe when HideStrb
//   is set) picks the active banks. Each active bank receives its slice through a
//   registered request FIFO. Bank responses are buffered per bank and merged back
//   in grant order once every bank active in the oldest transaction has answered.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i/gnt_o                    input request handshake (gnt_o combinational)
//   addr_i, size_i, wdata_i,
//   strb_i, user_i, we_i           request payload
//   rvalid_o, rdata_o, err_o       merged response, single-cycle pulse
//   bank_req_o/bank_gnt_i          per-bank request handshake
//   bank_addr_o, bank_wdata_o,
//   bank_strb_o, bank_user_o,
//   bank_we_o                      per-bank request payload
//   bank_rvalid_i, bank_rdata_i,
//   bank_err_i                     per-bank response
module mem_to_banks_sized #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned UserWidth = 1,
  parameter bit          HideStrb  = 1'b1,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned FifoDepth = 2,
  localparam int unsigned DataBytes = DataWidth / 8,
  localparam int unsigned BankBytes = DataBytes / NumBanks,
  localparam int unsigned BankWidth = DataWidth / NumBanks,
  localparam int unsigned SizeWidth = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_i,
  output logic                                gnt_o,
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [SizeWidth-1:0]                size_i,
  input  logic [DataWidth-1:0]                wdata_i,
  input  logic [DataBytes-1:0]                strb_i,
  input  logic [UserWidth-1:0]                user_i,
  input  logic                                we_i,
  output logic                                rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                err_o,
  output logic [NumBanks-1:0]                 bank_req_o,
  input  logic [NumBanks-1:0]                 bank_gnt_i,
  output logic [NumBanks-1:0][AddrWidth-1:0]  bank_addr_o,
  output logic [NumBanks-1:0][BankWidth-1:0]  bank_wdata_o,
  output logic [NumBanks-1:0][BankBytes-1:0]  bank_strb_o,
  output logic [NumBanks-1:0][UserWidth-1:0]  bank_user_o,
  output logic [NumBanks-1:0]                 bank_we_o,
  input  logic [NumBanks-1:0]                 bank_rvalid_i,
  input  logic [NumBanks-1:0][BankWidth-1:0]  bank_rdata_i,
  input  logic [NumBanks-1:0]                 bank_err_i
);

  localparam int unsigned OffW   = $clog2(DataBytes);
  localparam int unsigned OffW1  = OffW + 1;
  localparam int unsigned RqPtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned RqCntW = $clog2(FifoDepth + 1);
  localparam int unsigned RsPtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned RsCntW = $clog2(MaxTrans + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [BankWidth-1:0] wdata;
    logic [BankBytes-1:0] strb;
    logic [UserWidth-1:0] user;
    logic                 we;
  } req_t;

  typedef struct packed {
    logic [BankWidth-1:0] rdata;
    logic                 err;
  } rsp_t;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [RqPtrW-1:0] rq_ptr_next(input logic [RqPtrW-1:0] ptr);
    if (ptr == RqPtrW'(FifoDepth - 1)) return '0;
    else return ptr + RqPtrW'(1);
  endfunction

  function automatic logic [RsPtrW-1:0] rs_ptr_next(input logic [RsPtrW-1:0] ptr);
    if (ptr == RsPtrW'(MaxTrans - 1)) return '0;
    else return ptr + RsPtrW'(1);
  endfunction

  logic [OffW1-1:0]     size_bytes_s;
  logic [OffW-1:0]      off_s;
  logic [DataBytes-1:0] byte_mask_s;
  logic [NumBanks-1:0]  bank_active_s;
  logic [NumBanks-1:0]  req_full_s;
  logic [NumBanks-1:0]  rsp_empty_s;
  logic [NumBanks-1:0][BankWidth-1:0] rsp_data_s;
  logic [NumBanks-1:0]  rsp_err_s;
  logic [AddrWidth-1:0] bank_base_s;
  logic [NumBanks-1:0]  head_mask_s;
  logic                 rvalid_s;

  logic [NumBanks-1:0]  mask_mem_r [MaxTrans];
  logic [RsPtrW-1:0]    mask_wptr_r;
  logic [RsPtrW-1:0]    mask_rptr_r;
  logic [RsCntW-1:0]    mask_cnt_r;
  logic [RsCntW-1:0]    outstanding_r;

  assign bank_base_s = {addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};

  // Byte mask: offset aligned down to the access size, sizes at or above the bus width select everything.
  always_comb begin
    size_bytes_s = OffW1'(1) << size_i;
    off_s        = addr_i[OffW-1:0] & ~(size_bytes_s[OffW-1:0] - OffW'(1));
    byte_mask_s  = '0;
    if (size_i >= SizeWidth'(OffW)) begin
      byte_mask_s = '1;
    end else begin
      for (int b = 0; b < int'(DataBytes); b++) begin
        byte_mask_s[b] = (OffW1'(b) >= {1'b0, off_s}) &&
                         (OffW1'(b) < ({1'b0, off_s} + size_bytes_s));
      end
    end
  end

  // A bank is active when the access touches it; hidden writes also need a non-zero strobe slice.
  always_comb begin
    bank_active_s = '0;
    for (int i = 0; i < int'(NumBanks); i++) begin
      bank_active_s[i] = (|byte_mask_s[i*BankBytes +: BankBytes]) &
                         (~(HideStrb & we_i) | (|strb_i[i*BankBytes +: BankBytes]));
    end
  end

  // Only banks that take part may stall the request.
  assign gnt_o = req_i & ~(|(bank_active_s & req_full_s)) &
                 (outstanding_r < RsCntW'(MaxTrans));

  // Response completes once every bank of the oldest transaction has data; an empty mask completes at once.
  assign head_mask_s = mask_mem_r[mask_rptr_r];
  assign rvalid_s    = (mask_cnt_r != '0) & (&(~head_mask_s | ~rsp_empty_s));
  assign rvalid_o    = rvalid_s;

  // Merge bank responses; inactive slices and idle cycles read as zero.
  always_comb begin
    rdata_o = '0;
    err_o   = 1'b0;
    if (rvalid_s) begin
      for (int i = 0; i < int'(NumBanks); i++) begin
        rdata_o[i*BankWidth +: BankWidth] = head_mask_s[i] ? rsp_data_s[i] : '0;
        err_o = err_o | (head_mask_s[i] & rsp_err_s[i]);
      end
    end else begin
      rdata_o = '0;
      err_o   = 1'b0;
    end
  end

  // Outstanding transaction counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_r <= '0;
    end else begin
      case ({gnt_o, rvalid_s})
        2'b10:   outstanding_r <= outstanding_r + RsCntW'(1);
        2'b01:   outstanding_r <= outstanding_r - RsCntW'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // In-order FIFO of active-bank masks, one entry per granted transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(MaxTrans); k++) mask_mem_r[k] <= '0;
      mask_wptr_r <= '0;
      mask_rptr_r <= '0;
      mask_cnt_r  <= '0;
    end else begin
      if (gnt_o) begin
        mask_mem_r[mask_wptr_r] <= bank_active_s;
        mask_wptr_r             <= rs_ptr_next(mask_wptr_r);
      end
      if (rvalid_s) mask_rptr_r <= rs_ptr_next(mask_rptr_r);
      case ({gnt_o, rvalid_s})
        2'b10:   mask_cnt_r <= mask_cnt_r + RsCntW'(1);
        2'b01:   mask_cnt_r <= mask_cnt_r - RsCntW'(1);
        default: mask_cnt_r <= mask_cnt_r;
      endcase
    end
  end

  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    req_t              req_mem_r [FifoDepth];
    logic [RqPtrW-1:0] req_wptr_r;
    logic [RqPtrW-1:0] req_rptr_r;
    logic [RqCntW-1:0] req_cnt_r;
    logic              req_push_s;
    logic              req_pop_s;
    req_t              req_in_s;
    req_t              req_head_s;
    rsp_t              rsp_mem_r [MaxTrans];
    logic [RsPtrW-1:0] rsp_wptr_r;
    logic [RsPtrW-1:0] rsp_rptr_r;
    logic [RsCntW-1:0] rsp_cnt_r;
    logic              rsp_full_s;
    logic              rsp_push_s;
    logic              rsp_pop_s;
    rsp_t              rsp_head_s;

    assign req_in_s   = {bank_base_s + AddrWidth'(g * BankBytes),
                         wdata_i[g*BankWidth +: BankWidth],
                         strb_i[g*BankBytes +: BankBytes], user_i, we_i};
    assign req_push_s = gnt_o & bank_active_s[g];
    assign req_pop_s  = bank_req_o[g] & bank_gnt_i[g];
    assign req_head_s = req_mem_r[req_rptr_r];
    assign req_full_s[g] = (req_cnt_r == RqCntW'(FifoDepth));

    assign bank_req_o[g]   = (req_cnt_r != '0);
    assign bank_addr_o[g]  = req_head_s.addr;
    assign bank_wdata_o[g] = req_head_s.wdata;
    assign bank_strb_o[g]  = req_head_s.strb;
    assign bank_user_o[g]  = req_head_s.user;
    assign bank_we_o[g]    = req_head_s.we;

    // Per-bank request FIFO; the grant never pushes into a full one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < int'(FifoDepth); k++) req_mem_r[k] <= '0;
        req_wptr_r <= '0;
        req_rptr_r <= '0;
        req_cnt_r  <= '0;
      end else begin
        if (req_push_s) begin
          req_mem_r[req_wptr_r] <= req_in_s;
          req_wptr_r            <= rq_ptr_next(req_wptr_r);
        end
        if (req_pop_s) req_rptr_r <= rq_ptr_next(req_rptr_r);
        case ({req_push_s, req_pop_s})
          2'b10:   req_cnt_r <= req_cnt_r + RqCntW'(1);
          2'b01:   req_cnt_r <= req_cnt_r - RqCntW'(1);
          default: req_cnt_r <= req_cnt_r;
        endcase
      end
    end

    // At most MaxTrans responses can be pending per bank, so the guard only drops stray beats.
    assign rsp_full_s     = (rsp_cnt_r == RsCntW'(MaxTrans));
    assign rsp_pop_s      = rvalid_s & head_mask_s[g];
    assign rsp_push_s     = bank_rvalid_i[g] & (~rsp_full_s | rsp_pop_s);
    assign rsp_head_s     = rsp_mem_r[rsp_rptr_r];
    assign rsp_empty_s[g] = (rsp_cnt_r == '0);
    assign rsp_data_s[g]  = rsp_head_s.rdata;
    assign rsp_err_s[g]   = rsp_head_s.err;

    // Per-bank response FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < int'(MaxTrans); k++) rsp_mem_r[k] <= '0;
        rsp_wptr_r <= '0;
        rsp_rptr_r <= '0;
        rsp_cnt_r  <= '0;
      end else begin
        if (rsp_push_s) begin
          rsp_mem_r[rsp_wptr_r] <= {bank_rdata_i[g], bank_err_i[g]};
          rsp_wptr_r            <= rs_ptr_next(rsp_wptr_r);
        end
        if (rsp_pop_s) rsp_rptr_r <= rs_ptr_next(rsp_rptr_r);
        case ({rsp_push_s, rsp_pop_s})
          2'b10:   rsp_cnt_r <= rsp_cnt_r + RsCntW'(1);
          2'b01:   rsp_cnt_r <= rsp_cnt_r - RsCntW'(1);
          default: rsp_cnt_r <= rsp_cnt_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_to_banks_sized.sv
// Self-checking bench for mem_to_banks_sized with 64-bit data and four banks.
module tb_mem_to_banks_sized;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_i;
  logic             gnt_o;
  logic [31:0]      addr_i;
  logic [2:0]       size_i;
  logic [63:0]      wdata_i;
  logic [7:0]       strb_i;
  logic [0:0]       user_i;
  logic             we_i;
  logic             rvalid_o;
  logic [63:0]      rdata_o;
  logic             err_o;
  logic [3:0]       bank_req_o;
  logic [3:0]       bank_gnt_i;
  logic [3:0][31:0] bank_addr_o;
  logic [3:0][15:0] bank_wdata_o;
  logic [3:0][1:0]  bank_strb_o;
  logic [3:0][0:0]  bank_user_o;
  logic [3:0]       bank_we_o;
  logic [3:0]       bank_rvalid_i;
  logic [3:0][15:0] bank_rdata_i;
  logic [3:0]       bank_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] wdata_v = 64'hDEAD_BEEF_CAFE_F00D;
  logic [63:0] data_a  = 64'h4444_3333_2222_1111;
  logic [63:0] data_b  = 64'h8888_7777_6666_5555;
  logic [63:0] data_c  = 64'hC3C3_C2C2_C1C1_C0C0;

  mem_to_banks_sized dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .size_i(size_i), .wdata_i(wdata_i), .strb_i(strb_i),
    .user_i(user_i), .we_i(we_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .bank_req_o(bank_req_o), .bank_gnt_i(bank_gnt_i),
    .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
    .bank_strb_o(bank_strb_o), .bank_user_o(bank_user_o), .bank_we_o(bank_we_o),
    .bank_rvalid_i(bank_rvalid_i), .bank_rdata_i(bank_rdata_i),
    .bank_err_i(bank_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [3:0]  err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction: grant, bank request, bank response, merged response.
  task automatic run_vec(input vec_t v, input string tag);
    logic [63:0] exp_rd;
    @(negedge clk_i);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; size_i = v.size;
    strb_i = v.strb; wdata_i = wdata_v; user_i = 1'b1;
    #1 check({tag, "_gnt"}, gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    if (v.exp_mask == 4'h0) begin
      check({tag, "_zero_bank_req"}, bank_req_o, 4'h0);
      check({tag, "_zero_rvalid"}, rvalid_o, 1'b1);
      check({tag, "_zero_rdata"}, rdata_o, 64'h0);
      check({tag, "_zero_err"}, err_o, 1'b0);
    end else begin
      check({tag, "_bank_req"}, bank_req_o, v.exp_mask);
      for (int i = 0; i < 4; i++) begin
        if (v.exp_mask[i]) begin
          check($sformatf("%s_addr%0d", tag, i), bank_addr_o[i], v.exp_base + 32'(2 * i));
          check($sformatf("%s_we%0d", tag, i), bank_we_o[i], v.we);
          check($sformatf("%s_user%0d", tag, i), bank_user_o[i], 1'b1);
          if (v.we) begin
            check($sformatf("%s_wdata%0d", tag, i), bank_wdata_o[i], wdata_v[i*16 +: 16]);
            check($sformatf("%s_strb%0d", tag, i), bank_strb_o[i], v.strb[i*2 +: 2]);
          end
        end
      end
      bank_gnt_i = 4'hF;
      @(negedge clk_i);
      bank_gnt_i = 4'h0;
      #1 check({tag, "_bank_req_drained"}, bank_req_o, 4'h0);
      check({tag, "_rvalid_early"}, rvalid_o, 1'b0);
      bank_rvalid_i = v.exp_mask; bank_err_i = v.err; bank_rdata_i = data_a;
      @(negedge clk_i);
      bank_rvalid_i = 4'h0; bank_err_i = 4'h0;
      exp_rd = 64'h0;
      for (int i = 0; i < 4; i++) exp_rd[i*16 +: 16] = v.exp_mask[i] ? data_a[i*16 +: 16] : 16'h0;
      #1 check({tag, "_rvalid"}, rvalid_o, 1'b1);
      check({tag, "_rdata"}, rdata_o, exp_rd);
      check({tag, "_err"}, err_o, |(v.err & v.exp_mask));
    end
    @(negedge clk_i);
    #1 check({tag, "_rvalid_pulse"}, rvalid_o, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h100, 3'd3, 8'h00, 4'h0, 4'hF, 32'h100};
    vecs[1]  = '{1'b0, 32'h104, 3'd1, 8'h00, 4'h0, 4'h4, 32'h100};
    vecs[2]  = '{1'b0, 32'h105, 3'd1, 8'h00, 4'h0, 4'h4, 32'h100};
    vecs[3]  = '{1'b0, 32'h103, 3'd0, 8'h00, 4'h0, 4'h2, 32'h100};
    vecs[4]  = '{1'b0, 32'h10F, 3'd2, 8'h00, 4'h0, 4'hC, 32'h108};
    vecs[5]  = '{1'b0, 32'h200, 3'd7, 8'h00, 4'h0, 4'hF, 32'h200};
    vecs[6]  = '{1'b0, 32'h100, 3'd2, 8'h00, 4'h0, 4'h3, 32'h100};
    vecs[7]  = '{1'b1, 32'h100, 3'd3, 8'h0F, 4'h0, 4'h3, 32'h100};
    vecs[8]  = '{1'b1, 32'h100, 3'd3, 8'h00, 4'h0, 4'h0, 32'h100};
    vecs[9]  = '{1'b1, 32'h101, 3'd0, 8'h02, 4'h0, 4'h1, 32'h100};
    vecs[10] = '{1'b1, 32'h101, 3'd0, 8'h04, 4'h0, 4'h0, 32'h100};
    vecs[11] = '{1'b0, 32'h100, 3'd3, 8'h00, 4'h8, 4'hF, 32'h100};
    vecs[12] = '{1'b0, 32'h100, 3'd1, 8'h00, 4'h8, 4'h1, 32'h100};
    vecs[13] = '{1'b1, 32'h3FA, 3'd1, 8'h0C, 4'h0, 4'h2, 32'h3F8};

    rst_ni = 1'b0; req_i = 1'b0; addr_i = 32'h0; size_i = 3'd0; wdata_i = 64'h0;
    strb_i = 8'h0; user_i = 1'b0; we_i = 1'b0; bank_gnt_i = 4'h0;
    bank_rvalid_i = 4'h0; bank_rdata_i = 64'h0; bank_err_i = 4'h0;
    repeat (2) @(negedge clk_i);
    #1 check("reset_bank_req", bank_req_o, 4'h0);
    check("reset_rvalid", rvalid_o, 1'b0);
    check("reset_rdata", rdata_o, 64'h0);
    check("reset_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int k = 0; k < 14; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // Staggered bank responses merge into one response after the last one.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; size_i = 3'd3;
    #1 check("stag_gnt", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0; bank_gnt_i = 4'hF;
    #1 check("stag_bank_req", bank_req_o, 4'hF);
    @(negedge clk_i);
    bank_gnt_i = 4'h0; bank_rdata_i = data_a; bank_rvalid_i = 4'b0001;
    @(negedge clk_i);
    #1 check("stag_wait0", rvalid_o, 1'b0);
    bank_rvalid_i = 4'b0100;
    @(negedge clk_i);
    #1 check("stag_wait1", rvalid_o, 1'b0);
    bank_rvalid_i = 4'b0010;
    @(negedge clk_i);
    #1 check("stag_wait2", rvalid_o, 1'b0);
    bank_rvalid_i = 4'b1000;
    @(negedge clk_i);
    bank_rvalid_i = 4'h0;
    #1 check("stag_rvalid", rvalid_o, 1'b1);
    check("stag_rdata", rdata_o, 64'h4444_3333_2222_1111);
    @(negedge clk_i);
    #1 check("stag_pulse", rvalid_o, 1'b0);

    // Bank 1 stalled: third request waits on the outstanding limit, responses stay ordered.
    @(negedge clk_i);
    bank_gnt_i = 4'b1101; req_i = 1'b1; addr_i = 32'h100; size_i = 3'd3;
    #1 check("bp_gnt1", gnt_o, 1'b1);
    @(negedge clk_i);
    addr_i = 32'h108;
    #1 check("bp_gnt2", gnt_o, 1'b1);
    check("bp_bank_req1", bank_req_o, 4'hF);
    @(negedge clk_i);
    addr_i = 32'h110;
    #1 check("bp_gnt3_blocked", gnt_o, 1'b0);
    @(negedge clk_i);
    #1 check("bp_gnt3_blocked2", gnt_o, 1'b0);
    check("bp_bank_req_stall", bank_req_o, 4'b0010);
    bank_rvalid_i = 4'b1101; bank_rdata_i = data_a;
    @(negedge clk_i);
    bank_rdata_i = data_b;
    #1 check("bp_wait_bank1", rvalid_o, 1'b0);
    @(negedge clk_i);
    bank_rvalid_i = 4'h0; bank_gnt_i = 4'hF;
    #1 check("bp_gnt3_blocked3", gnt_o, 1'b0);
    @(negedge clk_i);
    #1 check("bp_bank1_second", bank_req_o, 4'b0010);
    bank_rvalid_i = 4'b0010; bank_rdata_i = data_a;
    @(negedge clk_i);
    bank_rdata_i = data_b;
    #1 check("bp_rvalid1", rvalid_o, 1'b1);
    check("bp_rdata1", rdata_o, data_a);
    check("bp_gnt_at_rvalid1", gnt_o, 1'b0);
    @(negedge clk_i);
    bank_rvalid_i = 4'h0;
    #1 check("bp_rvalid2", rvalid_o, 1'b1);
    check("bp_rdata2", rdata_o, data_b);
    check("bp_gnt3_released", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1 check("bp_bank_req3", bank_req_o, 4'hF);
    check("bp_addr3", bank_addr_o[0], 32'h110);
    @(negedge clk_i);
    #1 check("bp_bank_req3_drained", bank_req_o, 4'h0);
    bank_rvalid_i = 4'hF; bank_rdata_i = data_c;
    @(negedge clk_i);
    bank_rvalid_i = 4'h0; bank_gnt_i = 4'h0;
    #1 check("bp_rvalid3", rvalid_o, 1'b1);
    check("bp_rdata3", rdata_o, data_c);
    @(negedge clk_i);
    #1 check("bp_idle", rvalid_o, 1'b0);

    // Asynchronous reset with two reads in flight.
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h100; size_i = 3'd3;
    #1 check("rst_gnt1", gnt_o, 1'b1);
    @(negedge clk_i);
    addr_i = 32'h108; bank_gnt_i = 4'hF;
    #1 check("rst_gnt2", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0; bank_gnt_i = 4'h0; bank_rvalid_i = 4'hF; bank_rdata_i = data_a;
    @(negedge clk_i);
    bank_rvalid_i = 4'h0;
    #1 check("rst_pre_rvalid", rvalid_o, 1'b1);
    check("rst_pre_bank_req", bank_req_o, 4'hF);
    #1 rst_ni = 1'b0;
    #1 check("rst_async_rvalid", rvalid_o, 1'b0);
    check("rst_async_rdata", rdata_o, 64'h0);
    check("rst_async_err", err_o, 1'b0);
    check("rst_async_bank_req", bank_req_o, 4'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1 check("rst_post_rvalid", rvalid_o, 1'b0);
    check("rst_post_bank_req", bank_req_o, 4'h0);
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
